// File: rtl/id_ex_alu_stage.sv
// -----------------------------------------------------------------------------
// id_ex_alu_stage
//
// Pipeline register between instruction decode and the ALU. Each accepted MIPS
// instruction is decoded into an ALU control bundle (operands plus select
// lines) and registered with a valid/ready handshake. The stage holds one
// bundle, sustains one transfer per cycle, and its bundle can be killed by
// flush.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid / in_ready  upstream handshake (in_ready = !out_valid || out_ready)
//   instr                32-bit MIPS instruction word
//   rs_val, rt_val       register-file read values
//   flush                kill the held bundle and any incoming instruction
//   out_valid/out_ready  downstream handshake
//   a, b                 ALU operands
//   ALUSel, CompSel      ALU operation / comparison select
//   AddSel, ArithSel     subtract / arithmetic-shift select
//   sign                 signed operation
//   dst, wb_en, branch   destination register, writeback enable, branch compare
//   illegal              unrecognised encoding (only with ID_EX_ILLEGAL_TRAP_EN)
//
// Build option: define ID_EX_ILLEGAL_TRAP_EN to add the registered 'illegal'
// output. Without it the port does not exist and unknown encodings just
// become NOP bundles.
//
// Encodings:
//   ALUSel  000 add/sub, 001 OR, 010 AND, 011 XOR, 100 SLL, 101 shift right,
//           110 compare
//   CompSel 000 GT, 001 GE, 010 LT, 011 LE, 100 EQ, 101 NE
// -----------------------------------------------------------------------------
module id_ex_alu_stage #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       instr,
    input  logic [DATA_W-1:0] rs_val,
    input  logic [DATA_W-1:0] rt_val,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] a,
    output logic [DATA_W-1:0] b,
    output logic [2:0]        ALUSel,
    output logic [2:0]        CompSel,
    output logic              AddSel,
    output logic              ArithSel,
    output logic              sign,
    output logic [4:0]        dst,
    output logic              wb_en,
    output logic              branch
`ifdef ID_EX_ILLEGAL_TRAP_EN
    ,
    output logic              illegal
`endif
);

    // Instruction fields. The rs/rt register numbers are not needed here
    // (the operand values arrive already read), except rt as a destination.
    logic [5:0]  opcode;
    logic [4:0]  rt_f;
    logic [4:0]  rd_f;
    logic [4:0]  shamt;
    logic [5:0]  funct;
    logic [15:0] imm;
    logic        unused_rs_field;

    assign opcode          = instr[31:26];
    assign rt_f            = instr[20:16];
    assign rd_f            = instr[15:11];
    assign shamt           = instr[10:6];
    assign funct           = instr[5:0];
    assign imm             = instr[15:0];
    assign unused_rs_field = ^instr[25:21];

    // Decoded bundle
    logic [DATA_W-1:0] a_next, b_next;
    logic [2:0]        alusel_next, compsel_next;
    logic              addsel_next, arithsel_next, sign_next;
    logic [4:0]        dst_next;
    logic              wb_en_next, branch_next;
    logic              legal;

    always_comb begin
        // Everything starts as the NOP bundle; each recognised encoding
        // overrides only what it needs, so unused controls stay 0.
        a_next        = '0;
        b_next        = '0;
        alusel_next   = 3'b001;
        compsel_next  = 3'b000;
        addsel_next   = 1'b0;
        arithsel_next = 1'b0;
        sign_next     = 1'b0;
        dst_next      = 5'd0;
        wb_en_next    = 1'b0;
        branch_next   = 1'b0;
        legal         = 1'b0;

        case (opcode)
            6'h00: begin
                legal = 1'b1;
                case (funct)
                    6'h20, 6'h21: begin
                        alusel_next = 3'b000;
                        sign_next   = ~funct[0];
                    end
                    6'h22, 6'h23: begin
                        alusel_next = 3'b000;
                        addsel_next = 1'b1;
                        sign_next   = ~funct[0];
                    end
                    6'h24: alusel_next = 3'b010;
                    6'h25: alusel_next = 3'b001;
                    6'h26: alusel_next = 3'b011;
                    6'h2A, 6'h2B: begin
                        alusel_next  = 3'b110;
                        addsel_next  = 1'b1;
                        compsel_next = 3'b010;
                        sign_next    = ~funct[0];
                    end
                    // funct[1] separates left from right shifts; funct[0]
                    // marks the arithmetic variant among the right shifts.
                    6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07: begin
                        alusel_next   = funct[1] ? 3'b101 : 3'b100;
                        arithsel_next = funct[1] & funct[0];
                    end
                    default: legal = 1'b0;
                endcase

                if (legal) begin
                    dst_next   = rd_f;
                    wb_en_next = 1'b1;
                    if (funct[5:3] == 3'b000) begin
                        // Shifts operate on rt; amount is shamt or rs_val.
                        a_next = rt_val;
                        b_next = funct[2] ? rs_val : {{(DATA_W-5){1'b0}}, shamt};
                    end else begin
                        a_next = rs_val;
                        b_next = rt_val;
                    end
                end
            end
            6'h08, 6'h09: begin
                legal       = 1'b1;
                a_next      = rs_val;
                b_next      = {{(DATA_W-16){imm[15]}}, imm};
                alusel_next = 3'b000;
                sign_next   = ~opcode[0];
                dst_next    = rt_f;
                wb_en_next  = 1'b1;
            end
            6'h0A, 6'h0B: begin
                legal        = 1'b1;
                a_next       = rs_val;
                b_next       = {{(DATA_W-16){imm[15]}}, imm};
                alusel_next  = 3'b110;
                addsel_next  = 1'b1;
                compsel_next = 3'b010;
                sign_next    = ~opcode[0];
                dst_next     = rt_f;
                wb_en_next   = 1'b1;
            end
            6'h0C, 6'h0D, 6'h0E: begin
                legal       = 1'b1;
                a_next      = rs_val;
                b_next      = {{(DATA_W-16){1'b0}}, imm};
                alusel_next = (opcode == 6'h0C) ? 3'b010 :
                              (opcode == 6'h0D) ? 3'b001 : 3'b011;
                dst_next    = rt_f;
                wb_en_next  = 1'b1;
            end
            6'h0F: begin
                // lui is executed as imm << 16 on the shifter.
                legal       = 1'b1;
                a_next      = {{(DATA_W-16){1'b0}}, imm};
                b_next      = DATA_W'(16);
                alusel_next = 3'b100;
                dst_next    = rt_f;
                wb_en_next  = 1'b1;
            end
            6'h04, 6'h05: begin
                legal        = 1'b1;
                a_next       = rs_val;
                b_next       = rt_val;
                alusel_next  = 3'b110;
                addsel_next  = 1'b1;
                compsel_next = opcode[0] ? 3'b101 : 3'b100;
                branch_next  = 1'b1;
            end
            default: legal = 1'b0;
        endcase

        // Writes to $0 are dropped here so later stages need not check.
        if (dst_next == 5'd0) begin
            wb_en_next = 1'b0;
        end
    end

`ifndef ID_EX_ILLEGAL_TRAP_EN
    logic unused_legal;
    assign unused_legal = legal;
`endif

    // Registered bundle
    logic              out_valid_reg;
    logic [DATA_W-1:0] a_reg, b_reg;
    logic [2:0]        alusel_reg, compsel_reg;
    logic              addsel_reg, arithsel_reg, sign_reg;
    logic [4:0]        dst_reg;
    logic              wb_en_reg, branch_reg;
`ifdef ID_EX_ILLEGAL_TRAP_EN
    logic              illegal_reg;
`endif

    assign in_ready = ~out_valid_reg | out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_reg <= 1'b0;
            a_reg         <= '0;
            b_reg         <= '0;
            alusel_reg    <= 3'b000;
            compsel_reg   <= 3'b000;
            addsel_reg    <= 1'b0;
            arithsel_reg  <= 1'b0;
            sign_reg      <= 1'b0;
            dst_reg       <= 5'd0;
            wb_en_reg     <= 1'b0;
            branch_reg    <= 1'b0;
`ifdef ID_EX_ILLEGAL_TRAP_EN
            illegal_reg   <= 1'b0;
`endif
        end else if (flush) begin
            // Flush wins over a same-cycle accept; data may stay stale.
            out_valid_reg <= 1'b0;
        end else if (in_valid && in_ready) begin
            out_valid_reg <= 1'b1;
            a_reg         <= a_next;
            b_reg         <= b_next;
            alusel_reg    <= alusel_next;
            compsel_reg   <= compsel_next;
            addsel_reg    <= addsel_next;
            arithsel_reg  <= arithsel_next;
            sign_reg      <= sign_next;
            dst_reg       <= dst_next;
            wb_en_reg     <= wb_en_next;
            branch_reg    <= branch_next;
`ifdef ID_EX_ILLEGAL_TRAP_EN
            illegal_reg   <= ~legal;
`endif
        end else if (out_ready) begin
            out_valid_reg <= 1'b0;
        end
    end

    assign out_valid = out_valid_reg;
    assign a         = a_reg;
    assign b         = b_reg;
    assign ALUSel    = alusel_reg;
    assign CompSel   = compsel_reg;
    assign AddSel    = addsel_reg;
    assign ArithSel  = arithsel_reg;
    assign sign      = sign_reg;
    assign dst       = dst_reg;
    assign wb_en     = wb_en_reg;
    assign branch    = branch_reg;
`ifdef ID_EX_ILLEGAL_TRAP_EN
    assign illegal   = illegal_reg;
`endif

endmodule

// File: tb/tb_id_ex_alu_stage.sv
// -----------------------------------------------------------------------------
// tb_id_ex_alu_stage
//
// Directed vectors for id_ex_alu_stage. The driver pushes the hand-computed
// bundle for each accepted instruction into a queue; a monitor on the falling
// edge compares every presented bundle against the queue head (so held
// bundles are re-checked each stall cycle) and pops it when consumed.
// -----------------------------------------------------------------------------
module tb_id_ex_alu_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instr;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  ALUSel;
    logic [2:0]  CompSel;
    logic        AddSel;
    logic        ArithSel;
    logic        sign;
    logic [4:0]  dst;
    logic        wb_en;
    logic        branch;
`ifdef ID_EX_ILLEGAL_TRAP_EN
    logic        illegal;
`endif

    always #5 clk = ~clk;

    id_ex_alu_stage #(.DATA_W(32)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .instr    (instr),
        .rs_val   (rs_val),
        .rt_val   (rt_val),
        .flush    (flush),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .a        (a),
        .b        (b),
        .ALUSel   (ALUSel),
        .CompSel  (CompSel),
        .AddSel   (AddSel),
        .ArithSel (ArithSel),
        .sign     (sign),
        .dst      (dst),
        .wb_en    (wb_en),
        .branch   (branch)
`ifdef ID_EX_ILLEGAL_TRAP_EN
        ,
        .illegal  (illegal)
`endif
    );

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  alusel;
        logic [2:0]  compsel;
        logic        addsel;
        logic        arithsel;
        logic        sign;
        logic [4:0]  dst;
        logic        wb_en;
        logic        branch;
        logic        illegal;
    } bundle_t;

    bundle_t q[$];
    int      n_cmp = 0;
    int      n_bad = 0;
    int      n_txn = 0;

    function automatic bundle_t mk(input logic [31:0] ea, input logic [31:0] eb,
                                   input logic [2:0] alu, input logic [2:0] comp,
                                   input logic add, input logic arith,
                                   input logic sgn, input logic [4:0] d,
                                   input logic wb, input logic br, input logic ill);
        bundle_t r;
        r.a        = ea;
        r.b        = eb;
        r.alusel   = alu;
        r.compsel  = comp;
        r.addsel   = add;
        r.arithsel = arith;
        r.sign     = sgn;
        r.dst      = d;
        r.wb_en    = wb;
        r.branch   = br;
`ifdef ID_EX_ILLEGAL_TRAP_EN
        r.illegal  = ill;
`else
        r.illegal  = 1'b0 & ill;
`endif
        return r;
    endfunction

    function automatic bundle_t act_bundle();
        bundle_t r;
        r.a        = a;
        r.b        = b;
        r.alusel   = ALUSel;
        r.compsel  = CompSel;
        r.addsel   = AddSel;
        r.arithsel = ArithSel;
        r.sign     = sign;
        r.dst      = dst;
        r.wb_en    = wb_en;
        r.branch   = branch;
`ifdef ID_EX_ILLEGAL_TRAP_EN
        r.illegal  = illegal;
`else
        r.illegal  = 1'b0;
`endif
        return r;
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h required %h", nm, act, exp);
        end
    endtask

    // Monitor: every presented bundle must match the queue head.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && out_valid === 1'b1) begin
            if (q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_bundle: got %h required none", act_bundle());
            end else begin
                chk("bundle", act_bundle(), q[0]);
                if (out_ready) begin
                    n_txn++;
                    $display("txn %0d: a=%h b=%h ALUSel=%b CompSel=%b dst=%0d wb_en=%b branch=%b",
                             n_txn, a, b, ALUSel, CompSel, dst, wb_en, branch);
                    void'(q.pop_front());
                end
            end
        end
    end

    // Present one instruction and hold it until accepted (bounded wait).
    task automatic send(input logic [31:0] i, input logic [31:0] rs,
                        input logic [31:0] rt, input bundle_t e);
        int  waited;
        bit  done;
        waited   = 0;
        done     = 0;
        instr    = i;
        rs_val   = rs;
        rt_val   = rt;
        in_valid = 1'b1;
        while (!done) begin
            @(negedge clk);
            if (in_ready) begin
                @(posedge clk);
                q.push_back(e);
                done = 1;
            end else begin
                waited++;
                if (waited > 50) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL accept_timeout: got in_ready=0 for 50 cycles required 1");
                    done = 1;
                end
                @(posedge clk);
            end
        end
        #1 in_valid = 1'b0;
    endtask

    initial begin
        #500000;
        n_bad++;
        $display("FAIL watchdog: got no finish required finish before timeout");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        instr     = '0;
        rs_val    = '0;
        rt_val    = '0;
        flush     = 1'b0;
        out_ready = 1'b1;

        // Reset state
        #3;
        chk("reset_bundle", act_bundle(), mk(0, 0, 3'b000, 3'b000, 0, 0, 0, 0, 0, 0, 0));
        chk("reset_out_valid", out_valid, 1'b0);
        chk("reset_in_ready", in_ready, 1'b1);
        @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Back-to-back stream, consumer always ready
        send(32'h00851020, 32'd5, 32'd7,
             mk(32'd5, 32'd7, 3'b000, 3'b000, 0, 0, 1, 5'd2, 1, 0, 0));                // add
        send(32'h2402FFFF, 32'h11, 32'h0,
             mk(32'h11, 32'hFFFFFFFF, 3'b000, 3'b000, 0, 0, 0, 5'd2, 1, 0, 0));        // addiu -1
        send(32'h3402FFFF, 32'h11, 32'h0,
             mk(32'h11, 32'h0000FFFF, 3'b001, 3'b000, 0, 0, 0, 5'd2, 1, 0, 0));        // ori
        send(32'h00021083, 32'h1234, 32'h80000000,
             mk(32'h80000000, 32'd2, 3'b101, 3'b000, 0, 1, 0, 5'd2, 1, 0, 0));         // sra
        send(32'h10220010, 32'hA, 32'hB,
             mk(32'hA, 32'hB, 3'b110, 3'b100, 1, 0, 0, 5'd0, 0, 1, 0));                // beq
        send(32'h14220010, 32'hA, 32'hB,
             mk(32'hA, 32'hB, 3'b110, 3'b101, 1, 0, 0, 5'd0, 0, 1, 0));                // bne
        send(32'h0022182A, 32'd3, 32'd9,
             mk(32'd3, 32'd9, 3'b110, 3'b010, 1, 0, 1, 5'd3, 1, 0, 0));                // slt
        send(32'h0022182B, 32'd3, 32'd9,
             mk(32'd3, 32'd9, 3'b110, 3'b010, 1, 0, 0, 5'd3, 1, 0, 0));                // sltu
        send(32'h00221822, 32'd20, 32'd6,
             mk(32'd20, 32'd6, 3'b000, 3'b000, 1, 0, 1, 5'd3, 1, 0, 0));               // sub
        send(32'h3C051234, 32'hDEAD, 32'hBEEF,
             mk(32'h1234, 32'd16, 3'b100, 3'b000, 0, 0, 0, 5'd5, 1, 0, 0));            // lui
        send(32'h20200005, 32'h40, 32'h0,
             mk(32'h40, 32'd5, 3'b000, 3'b000, 0, 0, 1, 5'd0, 0, 0, 0));               // addi to $0
        send(32'hFC000000, 32'h55, 32'h66,
             mk(32'h0, 32'h0, 3'b001, 3'b000, 0, 0, 0, 5'd0, 0, 0, 1));                // illegal opcode
        send(32'h00222007, 32'd4, 32'hF0000000,
             mk(32'hF0000000, 32'd4, 3'b101, 3'b000, 0, 1, 0, 5'd4, 1, 0, 0));         // srav
        send(32'h38268001, 32'h77, 32'h0,
             mk(32'h77, 32'h00008001, 3'b011, 3'b000, 0, 0, 0, 5'd6, 1, 0, 0));        // xori
        send(32'h2827FFFE, 32'h9, 32'h0,
             mk(32'h9, 32'hFFFFFFFE, 3'b110, 3'b010, 1, 0, 1, 5'd7, 1, 0, 0));         // slti
        send(32'h00224024, 32'hF0F0, 32'hFF00,
             mk(32'hF0F0, 32'hFF00, 3'b010, 3'b000, 0, 0, 0, 5'd8, 1, 0, 0));          // and
        send(32'h00024FC0, 32'h1, 32'h3,
             mk(32'h3, 32'd31, 3'b100, 3'b000, 0, 0, 0, 5'd9, 1, 0, 0));               // sll 31
        send(32'h0022183F, 32'h1, 32'h2,
             mk(32'h0, 32'h0, 3'b001, 3'b000, 0, 0, 0, 5'd0, 0, 0, 1));                // unknown funct

        // Drain, then backpressure: hold A for 3 cycles while B waits
        repeat (2) @(posedge clk);
        #1 out_ready = 1'b0;
        send(32'h00851020, 32'd100, 32'd200,
             mk(32'd100, 32'd200, 3'b000, 3'b000, 0, 0, 1, 5'd2, 1, 0, 0));
        instr    = 32'h00221822;
        rs_val   = 32'd50;
        rt_val   = 32'd8;
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall_in_ready", in_ready, 1'b0);
            @(posedge clk);
        end
        #1 out_ready = 1'b1;
        @(negedge clk);
        chk("release_in_ready", in_ready, 1'b1);
        @(posedge clk);
        q.push_back(mk(32'd50, 32'd8, 3'b000, 3'b000, 1, 0, 1, 5'd3, 1, 0, 0));
        #1 in_valid = 1'b0;
        @(negedge clk);
        chk("no_bubble_out_valid", out_valid, 1'b1);
        @(posedge clk);
        #1;

        // Flush of a held bundle plus an incoming instruction
        out_ready = 1'b0;
        send(32'h3402ABCD, 32'h1, 32'h0,
             mk(32'h1, 32'h0000ABCD, 3'b001, 3'b000, 0, 0, 0, 5'd2, 1, 0, 0));
        instr    = 32'h00851020;
        rs_val   = 32'd1;
        rt_val   = 32'd2;
        in_valid = 1'b1;
        flush    = 1'b1;
        @(posedge clk);
        #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        void'(q.pop_front());
        @(negedge clk);
        chk("flush_held_out_valid", out_valid, 1'b0);
        chk("flush_in_ready", in_ready, 1'b1);

        // Flush with an empty stage still kills the incoming instruction
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        flush    = 1'b1;
        @(posedge clk);
        #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        chk("flush_empty_out_valid", out_valid, 1'b0);

        // Asynchronous reset with a held bundle
        @(posedge clk);
        #1;
        send(32'h0022182A, 32'h5, 32'h6,
             mk(32'h5, 32'h6, 3'b110, 3'b010, 1, 0, 1, 5'd3, 1, 0, 0));
        #1 rst_n = 1'b0;
        #1;
        chk("async_reset_bundle", act_bundle(), mk(0, 0, 3'b000, 3'b000, 0, 0, 0, 0, 0, 0, 0));
        chk("async_reset_out_valid", out_valid, 1'b0);
        q.delete();
        @(posedge clk);
        #3 rst_n = 1'b1;
        @(negedge clk);
        chk("post_reset_out_valid", out_valid, 1'b0);
        chk("post_reset_in_ready", in_ready, 1'b1);

        // Recovery after reset
        @(posedge clk);
        #1 out_ready = 1'b1;
        send(32'h00851020, 32'd11, 32'd22,
             mk(32'd11, 32'd22, 3'b000, 3'b000, 0, 0, 1, 5'd2, 1, 0, 0));
        repeat (3) @(posedge clk);
        #1;
        chk("queue_drained", 128'(q.size()), 128'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/id_ex_alu_stage.md
ID_EX_ALU_STAGE -- requirements
Module: id_ex_alu_stage

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, operand/result width; only 32 is supported.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 in_valid  input  1  decoded instruction and operands present.
REQ-005 in_ready  output  1  stage can accept this cycle.
REQ-006 instr  input  32  MIPS instruction word.
REQ-007 rs_val, rt_val  input  32 each  register-file read values.
REQ-008 flush  input  1  kill held and incoming instruction.
REQ-009 out_valid  output  1  registered ALU bundle valid.
REQ-010 out_ready  input  1  execute stage consumes bundle.
REQ-011 a, b  output  32 each  ALU operands.
REQ-012 ALUSel, CompSel  output  3 each; AddSel, ArithSel, sign  output  1 each  ALU controls.
REQ-013 dst  output  5 destination register; wb_en  output  1 writeback enable; branch  output  1 compare drives branch.

Function
REQ-014 Encodings SHALL be: ALUSel 000 add/sub (AddSel=1 subtract), 001 OR, 010 AND, 011 XOR, 100 SLL, 101 shift right (ArithSel=1 arithmetic), 110 compare (AddSel=1); CompSel 000 GT, 001 GE, 010 LT, 011 LE, 100 EQ, 101 NE; sign=1 signed.
REQ-015 R-type (opcode 0) by funct: 20/21 add/addu, 22/23 sub/subu, 24 and, 25 or, 26 xor, 2A/2B slt/sltu (CompSel 010); a=rs_val, b=rt_val; sign=1 for add/sub/slt only; dst=rd, wb_en=1.
REQ-016 Shifts: funct 00/02/03 sll/srl/sra a=rt_val, b=zero-extended shamt; 04/06/07 sllv/srlv/srav a=rt_val, b=rs_val; ArithSel=1 only for sra/srav.
REQ-017 I-type: 08/09 addi/addiu, 0A/0B slti/sltiu sign-extend imm16; 0C/0D/0E andi/ori/xori zero-extend; a=rs_val, b=imm; sign=1 for addi/slti; dst=rt, wb_en=1.
REQ-018 lui (0F): a=zero-extended imm16, b=16, ALUSel 100, dst=rt, wb_en=1.
REQ-019 beq (04)/bne (05): a=rs_val, b=rt_val, ALUSel 110, AddSel=1, CompSel 100/101, sign=0, branch=1, wb_en=0, dst=0.
REQ-020 Any other encoding SHALL produce a NOP bundle: ALUSel 001, a=b=0, wb_en=0, branch=0.
REQ-021 Unused control bits SHALL be 0.
REQ-022 in_ready SHALL equal (!out_valid || out_ready); combinational, independent of in_valid.
REQ-023 Transfer occurs when in_valid && in_ready; bundle appears on outputs with out_valid=1 the next edge (latency 1).
REQ-024 While out_valid && !out_ready all outputs SHALL hold stable.
REQ-025 Simultaneous consume and accept SHALL load the new bundle with out_valid staying 1 (full throughput, no bubble).
REQ-026 flush SHALL clear out_valid at the next edge, overriding any accept in the same cycle; data registers may keep stale values.
REQ-027 dst=0 with wb_en=1 SHALL be forced to wb_en=0.

Reset
REQ-028 rst_n low SHALL immediately clear out_valid, a, b, ALUSel, CompSel, AddSel, ArithSel, sign, dst, wb_en, branch (and illegal) to 0, regardless of clk.
REQ-029 Reset mid-transfer SHALL discard the held bundle; after release in_ready=1.

Configuration
REQ-030 With ID_EX_ILLEGAL_TRAP_EN defined, output illegal (1 bit) SHALL be registered alongside the bundle, 1 for encodings of REQ-020, else 0; without it the port and logic SHALL be absent and REQ-020 alone applies.

Verification
REQ-031 instr=0x00851020 (add $2,$4,$5), rs_val=5, rt_val=7 -> next cycle out_valid=1, a=5, b=7, ALUSel=000, AddSel=0, sign=1, dst=2, wb_en=1.
REQ-032 instr=0x2402FFFF (addiu $2,$0,-1) -> b=0xFFFFFFFF, sign=0; instr=0x3402FFFF (ori) -> b=0x0000FFFF, ALUSel=001.
REQ-033 instr=0x00021083 (sra $2,$2,2), rt_val=0x80000000 -> a=0x80000000, b=2, ALUSel=101, ArithSel=1.
REQ-034 out_ready=0 for 3 cycles with new in_valid -> in_ready=0, outputs unchanged; out_ready=1 -> next bundle loads same edge, out_valid stays 1.
REQ-035 flush=1 with in_valid=1 and held bundle -> out_valid=0 next edge; rst_n pulse mid-stream -> all outputs 0 immediately.
REQ-036 instr=0xFC000000 with ID_EX_ILLEGAL_TRAP_EN -> illegal=1, wb_en=0, ALUSel=001; without macro -> NOP bundle only.
